// File: rtl/matrix_row_scanner.sv
// Time-multiplexed LED matrix row scanner with dwell timer,
// inter-row blanking and a double-buffered frame store.
module matrix_row_scanner #(
  parameter int ROWS           = 7,
  parameter int COLS           = 5,
  parameter int DWELL          = 1000,
  parameter int BLANK          = 4,
  parameter bit ROW_ACTIVE_LOW = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     load,
  input  logic [ROWS*COLS-1:0]     frame_data,
  output logic [ROWS-1:0]          row_out,
  output logic [COLS-1:0]          col_out,
  output logic [$clog2(ROWS)-1:0]  row_idx,
  output logic                     frame_start,
  output logic                     pending
);

  localparam int N    = ROWS * COLS;
  localparam int RW   = $clog2(ROWS);
  localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] DW_LAST =
    CW'(DWELL - 1);
  localparam logic [CW-1:0] BL_LAST =
    CW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [RW-1:0] LAST_ROW =
    RW'(ROWS - 1);
  localparam logic [ROWS-1:0] ROW_OFF =
    {ROWS{ROW_ACTIVE_LOW}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_DRIVE
  } state_t;

  state_t          r_state, w_state;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic [RW-1:0]   r_row, w_row;
  logic [N-1:0]    r_act, w_act;
  logic [N-1:0]    r_sh, w_sh;
  logic            r_pend, w_pend;
  logic            r_fs, w_fs;
  logic [ROWS-1:0] r_rows, w_rows;
  logic [COLS-1:0] r_cols, w_cols;
  logic            w_bnd, w_adv;
  logic            w_drive, w_stop;

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_row   = r_row;
    w_act   = r_act;
    w_sh    = r_sh;
    w_pend  = r_pend;
    w_fs    = 1'b0;
    w_rows  = ROW_OFF;
    w_cols  = '0;
    w_bnd   = 1'b0;
    w_adv   = 1'b0;
    w_drive = 1'b0;
    w_stop  = 1'b0;

    if (load) begin
      w_sh   = frame_data;
      w_pend = 1'b1;
    end

    unique case (r_state)
      S_IDLE: w_bnd = en;
      S_BLANK: begin
        if (!en) begin
          w_stop = 1'b1;
        end else if (r_cnt == BL_LAST) begin
          w_state = S_DRIVE;
          w_cnt   = '0;
          w_drive = 1'b1;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_DRIVE: begin
        if (!en) begin
          w_stop = 1'b1;
        end else if (r_cnt == DW_LAST) begin
          if (r_row == LAST_ROW) begin
            w_bnd = 1'b1;
          end else begin
            w_adv = 1'b1;
            w_row = r_row + 1'b1;
          end
        end else begin
          w_cnt   = r_cnt + 1'b1;
          w_drive = 1'b1;
        end
      end
      default: w_stop = 1'b1;
    endcase

    if (w_stop) begin
      w_state = S_IDLE;
      w_cnt   = '0;
      w_row   = '0;
    end

    // swap sees the pre-edge shadow; a coincident load stays pending
    if (w_bnd) begin
      w_row  = '0;
      w_fs   = 1'b1;
      w_pend = load;
      if (r_pend) w_act = r_sh;
    end

    if (w_bnd || w_adv) begin
      w_cnt = '0;
      if (BLANK == 0) begin
        w_state = S_DRIVE;
        w_drive = 1'b1;
      end else begin
        w_state = S_BLANK;
      end
    end

    if (w_drive) begin
      w_rows = (ROWS'(1) << w_row) ^ ROW_OFF;
      w_cols = COLS'(w_act >> (int'(w_row) * COLS));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_row   <= '0;
      r_act   <= '0;
      r_sh    <= '0;
      r_pend  <= 1'b0;
      r_fs    <= 1'b0;
      r_rows  <= ROW_OFF;
      r_cols  <= '0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_row   <= w_row;
      r_act   <= w_act;
      r_sh    <= w_sh;
      r_pend  <= w_pend;
      r_fs    <= w_fs;
      r_rows  <= w_rows;
      r_cols  <= w_cols;
    end
  end

  assign row_out     = r_rows;
  assign col_out     = r_cols;
  assign row_idx     = r_row;
  assign frame_start = r_fs;
  assign pending     = r_pend;

endmodule

// File: tb/tb_matrix_row_scanner.sv
// Bench for matrix_row_scanner: random frames checked cycle by
// cycle against a time-based model of the scan schedule.
module tb_matrix_row_scanner;

  localparam int R = 7;
  localparam int C = 5;
  localparam int N = R * C;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         en2;
  logic         load;
  logic [N-1:0] frame_data;

  logic [R-1:0] row1, row2, o_row;
  logic [C-1:0] col1, col2, o_col;
  logic [2:0]   idx1, idx2, o_idx;
  logic         fs1, fs2, o_fs;
  logic         pd1, pd2, o_pend;
  bit           sel;

  matrix_row_scanner #(
    .ROWS(R), .COLS(C), .DWELL(4),
    .BLANK(2), .ROW_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .load(load), .frame_data(frame_data),
    .row_out(row1), .col_out(col1),
    .row_idx(idx1), .frame_start(fs1),
    .pending(pd1)
  );

  matrix_row_scanner #(
    .ROWS(R), .COLS(C), .DWELL(4),
    .BLANK(0), .ROW_ACTIVE_LOW(1'b1)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2),
    .load(load), .frame_data(frame_data),
    .row_out(row2), .col_out(col2),
    .row_idx(idx2), .frame_start(fs2),
    .pending(pd2)
  );

  assign o_row  = sel ? row2 : row1;
  assign o_col  = sel ? col2 : col1;
  assign o_idx  = sel ? idx2 : idx1;
  assign o_fs   = sel ? fs2  : fs1;
  assign o_pend = sel ? pd2  : pd1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;
  int cyc_n;

  // model: scan position is just elapsed time within the frame
  int           m_B, m_D;
  bit           m_low;
  bit           m_scan;
  int           m_t;
  logic [N-1:0] m_act, m_sh;
  bit           m_pend;

  logic [R-1:0] e_row;
  logic [C-1:0] e_col;
  logic [2:0]   e_idx;
  logic         e_fs, e_pend;

  task automatic model_reset();
    m_scan = 0;
    m_t    = 0;
    m_act  = '0;
    m_sh   = '0;
    m_pend = 0;
  endtask

  task automatic model_step(bit e, bit l, logic [N-1:0] d);
    int  p;
    bit  bnd;
    p   = R * (m_B + m_D);
    bnd = e && (!m_scan || (m_t % p == p - 1));
    if (!e) begin
      m_scan = 0;
      m_t    = 0;
    end else if (!m_scan) begin
      m_scan = 1;
      m_t    = 0;
    end else begin
      m_t++;
    end
    if (bnd) begin
      if (m_pend) m_act = m_sh;
      m_pend = 0;
    end
    if (l) begin
      m_sh   = d;
      m_pend = 1;
    end
  endtask

  task automatic compute_exp();
    int p, tm, r, ph;
    logic [N-1:0] sh;
    p      = R * (m_B + m_D);
    e_pend = m_pend;
    e_row  = '0;
    e_col  = '0;
    e_idx  = '0;
    e_fs   = 0;
    if (m_scan) begin
      tm    = m_t % p;
      r     = tm / (m_B + m_D);
      ph    = tm % (m_B + m_D);
      e_idx = 3'(r);
      e_fs  = (tm == 0);
      if (ph >= m_B) begin
        e_row = R'(1) << r;
        sh    = m_act >> (r * C);
        e_col = sh[C-1:0];
      end
    end
    if (m_low) e_row = ~e_row;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(sel ? en2 : en, load, frame_data);
    @(negedge clk);
    cyc_n++;
    compute_exp();
  endtask

  function automatic logic [N-1:0] rnd_frame();
    return N'({$urandom(), $urandom()});
  endfunction

  task automatic test_reset();
    rst_n = 0;
    cyc();
    cyc();
    n_chk++;
    if ({row1, col1, idx1, fs1, pd1} !== '0) begin
      n_fail++;
      $display("FAIL reset_init got %b%b%b%b%b want 0",
               row1, col1, idx1, fs1, pd1);
    end
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_chk++;
      if ({o_row, o_col, o_idx, o_fs, o_pend} !==
          {e_row, e_col, e_idx, e_fs, e_pend}) begin
        n_fail++;
        $display("FAIL reset_idle c%0d got r=%b c=%b i=%0d",
                 cyc_n, o_row, o_col, o_idx);
      end
    end
    frame_data = rnd_frame();
    load = 1;
    cyc();
    load = 0;
    en = 1;
    for (int i = 0; i < 10; i++) cyc();
    frame_data = rnd_frame();
    load = 1;
    cyc();
    load = 0;
    n_chk++;
    if (o_row === '0 || o_pend !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre got r=%b p=%b want drive,p=1",
               o_row, o_pend);
    end
    #2 rst_n = 0;
    #1;
    n_chk++;
    if ({row1, col1, idx1, pd1} !== '0) begin
      n_fail++;
      $display("FAIL reset_async got r=%b c=%b i=%0d p=%b want 0",
               row1, col1, idx1, pd1);
    end
    model_reset();
    en = 0;
    cyc();
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_chk++;
      if ({o_row, o_col, o_idx, o_fs, o_pend} !==
          {e_row, e_col, e_idx, e_fs, e_pend}) begin
        n_fail++;
        $display("FAIL reset_rel c%0d got r=%b c=%b want r=%b c=%b",
                 cyc_n, o_row, o_col, e_row, e_col);
      end
    end
  endtask

  task automatic test_scan_order();
    int fsq[$];
    for (int r = 0; r < R; r++) frame_data[r*C +: C] = C'(r + 1);
    load = 1;
    cyc();
    load = 0;
    en = 1;
    for (int i = 0; i < 2 * 42 + 3; i++) begin
      cyc();
      if (o_fs === 1'b1) fsq.push_back(cyc_n);
      n_chk++;
      if ({o_row, o_col, o_idx, o_fs, o_pend} !==
          {e_row, e_col, e_idx, e_fs, e_pend}) begin
        n_fail++;
        $display("FAIL scan c%0d got r=%b c=%0d i=%0d f=%b want r=%b c=%0d i=%0d f=%b",
                 cyc_n, o_row, o_col, o_idx, o_fs,
                 e_row, e_col, e_idx, e_fs);
      end
    end
    n_chk++;
    if (fsq.size() < 2 || fsq[1] - fsq[0] != 42) begin
      n_fail++;
      $display("FAIL scan_period got n=%0d gap=%0d want 42",
               fsq.size(), fsq.size() > 1 ? fsq[1] - fsq[0] : -1);
    end
  endtask

  task automatic test_double_buffer();
    for (int i = 0; i < 10; i++) cyc();
    frame_data = '1;
    load = 1;
    cyc();
    load = 0;
    frame_data = rnd_frame();
    n_chk++;
    if (o_pend !== 1'b1) begin
      n_fail++;
      $display("FAIL dbuf_pend got %b want 1", o_pend);
    end
    for (int i = 0; i < 80; i++) begin
      cyc();
      n_chk++;
      if ({o_row, o_col, o_idx, o_fs, o_pend} !==
          {e_row, e_col, e_idx, e_fs, e_pend}) begin
        n_fail++;
        $display("FAIL dbuf c%0d got r=%b c=%b p=%b want r=%b c=%b p=%b",
                 cyc_n, o_row, o_col, o_pend,
                 e_row, e_col, e_pend);
      end
    end
  endtask

  task automatic test_simultaneous();
    int k;
    frame_data = rnd_frame();
    load = 1;
    cyc();
    load = 0;
    k = 0;
    while (!(m_scan && m_t % 42 == 41) && k < 100) begin
      cyc();
      k++;
    end
    n_chk++;
    if (k >= 100) begin
      n_fail++;
      $display("FAIL simul_wait got timeout want boundary");
    end
    frame_data = rnd_frame();
    load = 1;
    cyc();
    load = 0;
    n_chk++;
    if (o_pend !== 1'b1 || o_fs !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_bnd got p=%b f=%b want 1,1",
               o_pend, o_fs);
    end
    for (int i = 0; i < 90; i++) begin
      cyc();
      n_chk++;
      if ({o_row, o_col, o_idx, o_fs, o_pend} !==
          {e_row, e_col, e_idx, e_fs, e_pend}) begin
        n_fail++;
        $display("FAIL simul c%0d got r=%b c=%b p=%b want r=%b c=%b p=%b",
                 cyc_n, o_row, o_col, o_pend,
                 e_row, e_col, e_pend);
      end
    end
  endtask

  task automatic test_en_drop();
    int k;
    k = 0;
    while (!(e_idx == 3 && e_row != '0) && k < 100) begin
      cyc();
      k++;
    end
    n_chk++;
    if (k >= 100) begin
      n_fail++;
      $display("FAIL endrop_wait got timeout want row 3");
    end
    en = 0;
    cyc();
    n_chk++;
    if ({o_row, o_col, o_idx, o_fs} !== '0) begin
      n_fail++;
      $display("FAIL endrop_off got r=%b c=%b i=%0d want 0",
               o_row, o_col, o_idx);
    end
    cyc();
    en = 1;
    cyc();
    n_chk++;
    if (o_fs !== 1'b1 || o_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL endrop_restart got f=%b i=%0d want 1,0",
               o_fs, o_idx);
    end
    for (int i = 0; i < 50; i++) begin
      cyc();
      n_chk++;
      if ({o_row, o_col, o_idx, o_fs, o_pend} !==
          {e_row, e_col, e_idx, e_fs, e_pend}) begin
        n_fail++;
        $display("FAIL endrop c%0d got r=%b c=%b want r=%b c=%b",
                 cyc_n, o_row, o_col, e_row, e_col);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en   = ($urandom_range(0, 60) != 0);
      load = ($urandom_range(0, 9) == 0);
      frame_data = rnd_frame();
      cyc();
      n_chk++;
      if ({o_row, o_col, o_idx, o_fs, o_pend} !==
          {e_row, e_col, e_idx, e_fs, e_pend}) begin
        n_fail++;
        $display("FAIL random c%0d got r=%b c=%b i=%0d f=%b p=%b want r=%b c=%b i=%0d f=%b p=%b",
                 cyc_n, o_row, o_col, o_idx, o_fs, o_pend,
                 e_row, e_col, e_idx, e_fs, e_pend);
      end
    end
    load = 0;
  endtask

  task automatic test_active_low();
    int fsq[$];
    en  = 0;
    en2 = 0;
    rst_n = 0;
    cyc();
    sel   = 1;
    m_B   = 0;
    m_low = 1;
    model_reset();
    rst_n = 1;
    cyc();
    n_chk++;
    if (o_row !== 7'h7F || o_col !== '0) begin
      n_fail++;
      $display("FAIL alow_idle got r=%b c=%b want 1111111,0",
               o_row, o_col);
    end
    frame_data = rnd_frame();
    load = 1;
    cyc();
    load = 0;
    en2 = 1;
    for (int i = 0; i < 70; i++) begin
      cyc();
      if (o_fs === 1'b1) fsq.push_back(cyc_n);
      if (i % 17 == 5) begin
        frame_data = rnd_frame();
        load = 1;
      end else begin
        load = 0;
      end
      n_chk++;
      if ({o_row, o_col, o_idx, o_fs, o_pend} !==
          {e_row, e_col, e_idx, e_fs, e_pend}) begin
        n_fail++;
        $display("FAIL alow c%0d got r=%b c=%b i=%0d want r=%b c=%b i=%0d",
                 cyc_n, o_row, o_col, o_idx,
                 e_row, e_col, e_idx);
      end
      if (o_idx === 3'd2 && e_idx == 2) begin
        n_chk++;
        if (o_row !== 7'b1111011) begin
          n_fail++;
          $display("FAIL alow_row2 got %b want 1111011", o_row);
        end
      end
    end
    load = 0;
    n_chk++;
    if (fsq.size() < 2 || fsq[1] - fsq[0] != 28) begin
      n_fail++;
      $display("FAIL alow_period got n=%0d gap=%0d want 28",
               fsq.size(), fsq.size() > 1 ? fsq[1] - fsq[0] : -1);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    cyc_n  = 0;
    sel    = 0;
    m_B    = 2;
    m_D    = 4;
    m_low  = 0;
    model_reset();
    rst_n      = 0;
    en         = 0;
    en2        = 0;
    load       = 0;
    frame_data = '0;
    test_reset();
    test_scan_order();
    test_double_buffer();
    test_simultaneous();
    test_en_drop();
    test_random();
    test_active_low();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
